// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle for the sequential ALU.
//   master : drives start, sel, in1, in2, sra; observes busy, done, out and flags.
//   slave  : the ALU itself.
// Parameters: WIDTH (operand width), SHW (shift-amount width, derived).
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
);
  logic             start;
  logic [3:0]       sel;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [SHW-1:0]   sra;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             z, s, p, g, e, l, dz;

  modport master (
    output start, sel, in1, in2, sra,
    input  busy, done, out, z, s, p, g, e, l, dz
  );

  modport slave (
    input  start, sel, in1, in2, sra,
    output busy, done, out, z, s, p, g, e, l, dz
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: parametrised sequential ALU, 16 opcodes.
//   Simple ops complete one cycle after the accepting edge. mul/div/mod iterate one bit
//   per cycle behind busy; done pulses once when out and flags are updated.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - alu_seq_if.slave (start/sel/in1/in2/sra in; busy/done/out/z/s/p/g/e/l/dz out)
// Build option: define ALU_SEQ_FAST_MUL_EN to make mul a single-cycle combinational op.
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

`ifdef ALU_SEQ_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
`else
  localparam bit FastMul = 1'b0;
`endif

  localparam logic [3:0] OpMul = 4'h2;
  localparam logic [3:0] OpDiv = 4'h3;
  localparam logic [3:0] OpMod = 4'h4;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

  state_e           r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-1:0] r_acc;   // mul partial product / div remainder
  logic [WIDTH-1:0] r_x;     // mul shifted multiplicand
  logic [WIDTH-1:0] r_y;     // mul remaining multiplier / div dividend->quotient
  logic [SHW-1:0]   r_cnt;
  logic             r_dz_pend;
  logic             r_busy, r_done, r_dz;
  logic [WIDTH-1:0] r_out;
  logic             r_z, r_s, r_p, r_g, r_e, r_l;

  function automatic logic [WIDTH-1:0] simple_op(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [SHW-1:0] sh);
    logic [2*WIDTH-1:0] dbl_l, dbl_r;
    logic [WIDTH-1:0]   res;
    // Rotates via a doubled operand; sh is SHW bits wide so it is already modulo WIDTH.
    dbl_l = {a, a} << sh;
    dbl_r = {a, a} >> sh;
    case (op)
      4'h0: res = a + b;
      4'h1: res = a - b;
`ifdef ALU_SEQ_FAST_MUL_EN
      4'h2: res = a * b;
`else
      4'h2: res = '0;
`endif
      4'h5: res = (a > b) ? a : b;
      4'h6: res = (a < b) ? a : b;
      4'h7: res = ~a;
      4'h8: res = ~(a & b);
      4'h9: res = ~(a | b);
      4'hA: res = ~(a ^ b);
      4'hB: res = a << sh;
      4'hC: res = $unsigned($signed(a) >>> sh);
      4'hD: res = a >> sh;
      4'hE: res = dbl_l[2*WIDTH-1:WIDTH];
      4'hF: res = dbl_r[WIDTH-1:0];
      default: res = '0;
    endcase
    return res;
  endfunction

  logic             w_iter, w_is_div, w_fire;
  logic [WIDTH-1:0] w_acc, w_x, w_y, w_b;
  logic [WIDTH-1:0] w_acc_n, w_x_n, w_y_n;
  logic [WIDTH:0]   w_rem_sh, w_diff;
  logic [WIDTH-1:0] w_fin_res, w_res, w_cmp_a, w_cmp_b;

  always_comb begin
    w_iter = (bus.sel == OpDiv) || (bus.sel == OpMod) || (!FastMul && (bus.sel == OpMul));
  end

  // One iteration step. In StIdle it runs on the raw inputs so the accepting edge
  // already performs the first iteration; that keeps the total latency at WIDTH+1.
  always_comb begin
    w_is_div = (r_state == StIdle) ? (bus.sel != OpMul) : (r_op != OpMul);
    if (r_state == StIdle) begin
      w_acc = '0;
      w_x   = bus.in1;
      w_y   = w_is_div ? bus.in1 : bus.in2;
      w_b   = bus.in2;
    end else begin
      w_acc = r_acc;
      w_x   = r_x;
      w_y   = r_y;
      w_b   = r_b;
    end
    w_rem_sh = {w_acc, w_y[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, w_b};
    if (w_is_div) begin
      w_acc_n = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_y_n   = {w_y[WIDTH-2:0], ~w_diff[WIDTH]};
      w_x_n   = w_x;
    end else begin
      w_acc_n = w_y[0] ? (w_acc + w_x) : w_acc;
      w_x_n   = w_x << 1;
      w_y_n   = w_y >> 1;
    end
  end

  always_comb begin
    if (r_dz_pend) begin
      w_fin_res = (r_op == OpDiv) ? '1 : r_a;
    end else if (r_op == OpDiv) begin
      w_fin_res = r_y;
    end else begin
      w_fin_res = r_acc;
    end
    w_fire  = (r_state == StFin) || ((r_state == StIdle) && bus.start && !w_iter);
    w_res   = (r_state == StFin) ? w_fin_res : simple_op(bus.sel, bus.in1, bus.in2, bus.sra);
    w_cmp_a = (r_state == StFin) ? r_a : bus.in1;
    w_cmp_b = (r_state == StFin) ? r_b : bus.in2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_cnt     <= '0;
      r_dz_pend <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_out     <= '0;
      r_z       <= 1'b0;
      r_s       <= 1'b0;
      r_p       <= 1'b0;
      r_g       <= 1'b0;
      r_e       <= 1'b0;
      r_l       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_op <= bus.sel;
            r_a  <= bus.in1;
            r_b  <= bus.in2;
            if (w_iter) begin
              r_busy <= 1'b1;
              if ((bus.sel != OpMul) && (bus.in2 == '0)) begin
                r_dz_pend <= 1'b1;
                r_state   <= StFin;
              end else begin
                r_dz_pend <= 1'b0;
                r_acc     <= w_acc_n;
                r_x       <= w_x_n;
                r_y       <= w_y_n;
                r_cnt     <= SHW'(WIDTH - 2);
                r_state   <= (bus.sel == OpMul) ? StMul : StDiv;
              end
            end
          end
        end
        StMul, StDiv: begin
          r_acc <= w_acc_n;
          r_x   <= w_x_n;
          r_y   <= w_y_n;
          if (r_cnt == '0) begin
            r_state <= StFin;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StFin: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase

      if (w_fire) begin
        r_out  <= w_res;
        r_done <= 1'b1;
        r_dz   <= (r_state == StFin) && r_dz_pend;
        r_z    <= (w_res == '0);
        r_s    <= w_res[WIDTH-1];
        r_p    <= ^w_res;
        r_g    <= (w_cmp_a > w_cmp_b);
        r_e    <= (w_cmp_a == w_cmp_b);
        r_l    <= (w_cmp_a < w_cmp_b);
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.out  = r_out;
  assign bus.z    = r_z;
  assign bus.s    = r_s;
  assign bus.p    = r_p;
  assign bus.g    = r_g;
  assign bus.e    = r_e;
  assign bus.l    = r_l;
  assign bus.dz   = r_dz;

endmodule
